bicubic_input_sequencer: RTL and testbench
==========================================

// Module: bicubic_input_sequencer
// PURPOSE
// - Front-end scheduler for the bicubic pipeline: converts AXI4-Stream video (tuser=SOF, tlast=EOL) into
//   pixel_in_valid / pixel_in_start_of_frame beats gated by the pipeline controller's pipeline_ready.
// - Checks frame geometry, resynchronises on errors by pulsing sclr, and appends flush beats after each frame.
// PARAMETERS
// - INPUT_WIDTH   960  active pixels per input line
// - INPUT_HEIGHT  540  active lines per input frame
// - PIXEL_WIDTH   24   bits per pixel (tdata width)
// - FLUSH_PIXELS  2    padding beats issued after the last pixel of a frame (>=1)
// PORTS
// - clk                      in   1   clock
// - aresetn                  in   1   asynchronous reset, active-low
// - clken                    in   1   global clock enable; all state frozen when low, s_axis_tready forced 0
// - s_axis_tdata             in   PW  input pixel
// - s_axis_tvalid            in   1   input beat valid
// - s_axis_tready            out  1   input beat accepted when tvalid & tready
// - s_axis_tuser             in   1   start of frame
// - s_axis_tlast             in   1   end of line
// - pipeline_ready           in   1   from bicubic_pipeline_controller
// - pixel_data               out  PW  pixel to reference-pixel buffer
// - pixel_in_valid           out  1   pixel beat to controller/buffer
// - pixel_in_start_of_frame  out  1   qualifies first beat of a frame
// - pixel_pad                out  1   current beat is a flush beat
// - sclr                     out  1   synchronous clear to the pipeline, 1-cycle pulse
// - frame_done               out  1   1-cycle pulse when last flush beat issues
// - err_flags                out  3   sticky {mid_sof, late_eol, early_eol}
// - err_clear                in   1   clears err_flags (takes priority over a new error same cycle)
// BEHAVIOUR
// - Reset: state IDLE, x=y=0, last_pixel=0, err_flags=0, sclr=0, frame_done=0; comb outputs low.
// - Datapath latency 0: pixel_in_valid = s_axis_tvalid & s_axis_tready in IDLE(SOF beat)/ACTIVE;
//   pixel_data = s_axis_tdata; in FLUSH pixel_in_valid = pipeline_ready & clken, pixel_data = last_pixel.
// - States:
//   IDLE:   tready=clken. Beat without tuser: dropped (no pixel_in_valid). Beat with tuser: forwarded with
//           start_of_frame=1, x<=1 (or 0,y<=1 if INPUT_WIDTH==1), -> ACTIVE. Beat sampled with pipeline_ready
//           requirement: tready = clken & (pipeline_ready | !tuser).
//   ACTIVE: tready = clken & pipeline_ready. Per accepted beat, in priority order:
//           tuser=1 -> mid_sof error, beat NOT accepted (tready=0 that cycle), -> RESYNC;
//           tlast=1 & x!=W-1 -> early_eol, beat consumed, -> RESYNC;
//           tlast=0 & x==W-1 -> late_eol, beat consumed, -> RESYNC;
//           else forward; x wraps W-1->0 with y+1; on x==W-1 & y==H-1 -> FLUSH, flush_cnt<=0.
//           last_pixel <= s_axis_tdata on every forwarded beat.
//   FLUSH:  tready=0. Each cycle with pipeline_ready & clken issues one pad beat (pixel_pad=1);
//           flush_cnt increments; on FLUSH_PIXELS-1 frame_done pulses next cycle, -> IDLE, x=y=0.
//   RESYNC: tready=0, sclr=1 for exactly one cycle, x=y=0, -> IDLE. Erroneous beats never reach pipeline
//           (tuser beat in mid_sof case is held at source and re-accepted in IDLE as a new frame).
// - pipeline_ready dropping mid-line simply stalls tready; counters hold. No beat is ever issued with
//   pipeline_ready=0.
// - err_flags bits set on detection, held until err_clear; simultaneous set/clear -> cleared.
// - Counter widths: x $clog2(INPUT_WIDTH), y $clog2(INPUT_HEIGHT), flush_cnt $clog2(FLUSH_PIXELS+1);
//   all compares against parameter-1 constants, no overflow possible.
// - aresetn assertion mid-frame: immediate return to reset state; no sclr pulse generated.
// STRUCTURE
// - Shared package bicubic_pkg: typedef enum logic[1:0] {SEQ_IDLE, SEQ_ACTIVE, SEQ_FLUSH, SEQ_RESYNC};
//   err_flags bit indices ERR_EARLY_EOL=0, ERR_LATE_EOL=1, ERR_MID_SOF=2.
// - One sub-module natural: bicubic_frame_geom_counter (x/y counters, line_end/frame_end flags).
// - Single FSM always_ff; tready/valid/data as always_comb from state.
// TESTING (W=4, H=3, FLUSH_PIXELS=2, ready tied 1 unless stated)
// - Clean frame 12 beats, SOF on beat0, tlast on beats 3/7/11 -> 12 valid beats, SOF on first only,
//   then 2 pixel_pad beats carrying beat11 data, frame_done 1 cycle, err_flags=0.
// - 3 junk beats before SOF -> all accepted, none forwarded; frame then processes normally.
// - tlast on beat 2 -> early_eol set, sclr pulses once, next SOF frame completes cleanly.
// - tuser on beat 6 -> mid_sof set, beat 6 stalled, sclr pulse, beat 6 forwarded as SOF of new frame.
// - pipeline_ready toggled 1/0 every 3 cycles -> no valid while ready=0, 12+2 beats total, order intact.
// - aresetn low during FLUSH -> outputs at reset values, next SOF accepted from IDLE.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared types and constants for the bicubic input front-end.
// Holds the sequencer state encoding, error-flag bit positions and a width helper.
package bicubic_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_ACTIVE = 2'd1,
        SEQ_FLUSH  = 2'd2,
        SEQ_RESYNC = 2'd3
    } seq_state_e;

    localparam int unsigned ERR_EARLY_EOL = 0;
    localparam int unsigned ERR_LATE_EOL  = 1;
    localparam int unsigned ERR_MID_SOF   = 2;
    localparam int unsigned ERR_NUM       = 3;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/bicubic_frame_geom_counter.sv
// Column/row tracker for the input sequencer: reports whether the beat at the input
// is the last pixel of a line and of a frame; wraps to the origin after the last pixel.
module bicubic_frame_geom_counter
    import bicubic_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 960,
    parameter int unsigned INPUT_HEIGHT = 540
) (
    input  logic clk,
    input  logic aresetn,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_line_end,
    output logic o_frame_end
);

    localparam int unsigned XW = clog2_min1(INPUT_WIDTH);
    localparam int unsigned YW = clog2_min1(INPUT_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(INPUT_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(INPUT_HEIGHT - 1);

    logic [XW-1:0] r_x;
    logic [XW-1:0] w_x_d;
    logic [YW-1:0] r_y;
    logic [YW-1:0] w_y_d;
    logic          w_line_end;
    logic          w_frame_end;

    assign w_line_end  = (r_x == X_LAST);
    assign w_frame_end = w_line_end & (r_y == Y_LAST);

    always_comb begin
        w_x_d = r_x;
        w_y_d = r_y;
        if (i_clear) begin
            w_x_d = '0;
            w_y_d = '0;
        end else if (i_advance) begin
            if (w_line_end) begin
                w_x_d = '0;
                w_y_d = w_frame_end ? '0 : r_y + 1'b1;
            end else begin
                w_x_d = r_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_x_d;
            r_y <= w_y_d;
        end
    end

    assign o_line_end  = w_line_end;
    assign o_frame_end = w_frame_end;

endmodule

// File: rtl/bicubic_input_sequencer.sv
// Front-end scheduler for the bicubic pipeline: turns AXI4-Stream video into pixel beats
// gated by pipeline_ready, checks line/frame geometry, resynchronises and pads each frame.
module bicubic_input_sequencer
    import bicubic_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 960,
    parameter int unsigned INPUT_HEIGHT = 540,
    parameter int unsigned PIXEL_WIDTH  = 24,
    parameter int unsigned FLUSH_PIXELS = 2
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   clken,
    input  logic [PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    input  logic                   pipeline_ready,
    output logic [PIXEL_WIDTH-1:0] pixel_data,
    output logic                   pixel_in_valid,
    output logic                   pixel_in_start_of_frame,
    output logic                   pixel_pad,
    output logic                   sclr,
    output logic                   frame_done,
    output logic [ERR_NUM-1:0]     err_flags,
    input  logic                   err_clear
);

    localparam int unsigned FCW = clog2_min1(FLUSH_PIXELS + 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_PIXELS - 1);

    seq_state_e             r_state;
    seq_state_e             w_state_d;
    logic [PIXEL_WIDTH-1:0] r_last_pixel;
    logic [FCW-1:0]         r_flush_cnt;
    logic [ERR_NUM-1:0]     r_err_flags;
    logic                   r_frame_done;

    logic                   w_tready;
    logic                   w_accept;
    logic                   w_in_idle;
    logic                   w_in_active;
    logic                   w_in_flush;
    logic                   w_in_resync;
    logic                   w_sof_beat;
    logic                   w_mid_sof;
    logic                   w_early_eol;
    logic                   w_late_eol;
    logic                   w_error;
    logic                   w_fwd;
    logic                   w_pad;
    logic                   w_flush_last;
    logic                   w_enter_flush;
    logic                   w_geom_clear;
    logic                   w_line_end;
    logic                   w_frame_end;
    logic [ERR_NUM-1:0]     w_err_set;

    bicubic_frame_geom_counter #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .INPUT_HEIGHT (INPUT_HEIGHT)
    ) u_geom (
        .clk         (clk),
        .aresetn     (aresetn),
        .i_clear     (w_geom_clear),
        .i_advance   (w_fwd),
        .o_line_end  (w_line_end),
        .o_frame_end (w_frame_end)
    );

    assign w_in_idle   = (r_state == SEQ_IDLE);
    assign w_in_active = (r_state == SEQ_ACTIVE);
    assign w_in_flush  = (r_state == SEQ_FLUSH);
    assign w_in_resync = (r_state == SEQ_RESYNC);

    // An SOF beat in IDLE starts a frame, so it needs the pipeline; junk beats are
    // drained regardless. In ACTIVE an SOF beat is refused and left at the source.
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            SEQ_IDLE:   w_tready = clken & (pipeline_ready | ~s_axis_tuser);
            SEQ_ACTIVE: w_tready = clken & pipeline_ready & ~(s_axis_tvalid & s_axis_tuser);
            default:    w_tready = 1'b0;
        endcase
    end

    assign w_accept      = s_axis_tvalid & w_tready;
    assign w_sof_beat    = w_in_idle & w_accept & s_axis_tuser;
    assign w_mid_sof     = w_in_active & clken & pipeline_ready & s_axis_tvalid & s_axis_tuser;
    assign w_early_eol   = w_in_active & w_accept & s_axis_tlast & ~w_line_end;
    assign w_late_eol    = w_in_active & w_accept & ~s_axis_tlast & w_line_end;
    assign w_error       = w_mid_sof | w_early_eol | w_late_eol;
    assign w_fwd         = w_sof_beat | (w_in_active & w_accept & ~w_early_eol & ~w_late_eol);
    assign w_pad         = w_in_flush & clken & pipeline_ready;
    assign w_flush_last  = w_pad & (r_flush_cnt == FLUSH_LAST);
    assign w_enter_flush = w_fwd & w_frame_end;
    assign w_geom_clear  = (w_in_resync & clken) | w_flush_last;

    always_comb begin
        w_err_set                = '0;
        w_err_set[ERR_EARLY_EOL] = w_early_eol;
        w_err_set[ERR_LATE_EOL]  = w_late_eol;
        w_err_set[ERR_MID_SOF]   = w_mid_sof;
    end

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic; every condition already carries clken, so state freezes with it.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            SEQ_IDLE: begin
                if (w_sof_beat) begin
                    w_state_d = w_frame_end ? SEQ_FLUSH : SEQ_ACTIVE;
                end
            end
            SEQ_ACTIVE: begin
                if (w_error) begin
                    w_state_d = SEQ_RESYNC;
                end else if (w_enter_flush) begin
                    w_state_d = SEQ_FLUSH;
                end
            end
            SEQ_FLUSH: begin
                if (w_flush_last) begin
                    w_state_d = SEQ_IDLE;
                end
            end
            SEQ_RESYNC: begin
                if (clken) begin
                    w_state_d = SEQ_IDLE;
                end
            end
            default: w_state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_last_pixel <= '0;
            r_flush_cnt  <= '0;
            r_err_flags  <= '0;
        end else if (clken) begin
            if (w_fwd) begin
                r_last_pixel <= s_axis_tdata;
            end
            if (w_enter_flush) begin
                r_flush_cnt <= '0;
            end else if (w_pad) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            // Clear wins over an error detected in the same cycle.
            if (err_clear) begin
                r_err_flags <= '0;
            end else begin
                r_err_flags <= r_err_flags | w_err_set;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_flush_last;
        end
    end

    // Output logic
    always_comb begin
        s_axis_tready           = w_tready;
        pixel_in_valid          = w_fwd | w_pad;
        pixel_in_start_of_frame = w_sof_beat;
        pixel_pad               = w_pad;
        sclr                    = w_in_resync & clken;
        pixel_data              = '0;
        if (w_fwd) begin
            pixel_data = s_axis_tdata;
        end else if (w_pad) begin
            pixel_data = r_last_pixel;
        end
    end

    assign frame_done = r_frame_done;
    assign err_flags  = r_err_flags;

endmodule

// File: tb/tb_bicubic_input_sequencer.sv
// Directed bench for bicubic_input_sequencer on a 4x3 frame with two flush beats.
// Output beats are logged at the falling edge and checked against hand-built expectations.
module tb_bicubic_input_sequencer;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned FP   = 2;
    localparam int unsigned PW   = 24;
    localparam int unsigned NPIX = W * H;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          clken = 1'b1;
    logic [PW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          pipeline_ready;
    logic [PW-1:0] pixel_data;
    logic          pixel_in_valid;
    logic          pixel_in_start_of_frame;
    logic          pixel_pad;
    logic          sclr;
    logic          frame_done;
    logic [2:0]    err_flags;
    logic          err_clear = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [PW+1:0] q_beat[$];
    int            n_sclr = 0;
    int            n_done = 0;
    int            n_bad_valid = 0;
    logic [2:0]    err_at_sclr = '0;

    bit tog_en = 1'b0;
    int tog_cnt;

    always #5 clk = ~clk;

    bicubic_input_sequencer #(
        .INPUT_WIDTH  (W),
        .INPUT_HEIGHT (H),
        .PIXEL_WIDTH  (PW),
        .FLUSH_PIXELS (FP)
    ) dut (
        .clk                     (clk),
        .aresetn                 (aresetn),
        .clken                   (clken),
        .s_axis_tdata            (s_axis_tdata),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tready           (s_axis_tready),
        .s_axis_tuser            (s_axis_tuser),
        .s_axis_tlast            (s_axis_tlast),
        .pipeline_ready          (pipeline_ready),
        .pixel_data              (pixel_data),
        .pixel_in_valid          (pixel_in_valid),
        .pixel_in_start_of_frame (pixel_in_start_of_frame),
        .pixel_pad               (pixel_pad),
        .sclr                    (sclr),
        .frame_done              (frame_done),
        .err_flags               (err_flags),
        .err_clear               (err_clear)
    );

    // Beat logger: {pad, sof, data} per issued beat.
    always @(negedge clk) begin
        if (aresetn) begin
            if (pixel_in_valid) q_beat.push_back({pixel_pad, pixel_in_start_of_frame, pixel_data});
            if (pixel_in_valid && !pipeline_ready) n_bad_valid++;
            if (sclr) begin
                n_sclr++;
                err_at_sclr = err_flags;
            end
            if (frame_done) n_done++;
        end
    end

    // pipeline_ready source: held high, or toggled every 3 cycles when tog_en is set.
    initial begin
        pipeline_ready = 1'b1;
        tog_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                tog_cnt++;
                if (tog_cnt == 3) begin
                    tog_cnt = 0;
                    pipeline_ready = ~pipeline_ready;
                end
            end else begin
                tog_cnt = 0;
                pipeline_ready = 1'b1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [PW-1:0] d, input logic u, input logic l);
        bit acc;
        acc = 1'b0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL send_accept data=%h got tready=0 want 1 within 200 cycles", d);
        end
    endtask

    task automatic send_frame(input logic [PW-1:0] base);
        for (int k = 0; k < NPIX; k++) begin
            send_beat(base + PW'(k), (k == 0), ((k % W) == W - 1));
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({pixel_in_valid, pixel_in_start_of_frame, pixel_pad, sclr, frame_done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 00000",
                     {pixel_in_valid, pixel_in_start_of_frame, pixel_pad, sclr, frame_done});
        end
        n_cmp++;
        if (err_flags !== 3'b000) begin
            n_err++;
            $display("FAIL reset_err_flags got %b want 000", err_flags);
        end
        n_cmp++;
        if (s_axis_tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tready got %b want 1", s_axis_tready);
        end
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        idle(2);
    endtask

    task automatic test_clean_frame;
        int b0;
        int d0;
        int s0;
        logic [PW-1:0] base;
        logic [PW+1:0] exp;
        base = 24'h100000;
        b0 = q_beat.size();
        d0 = n_done;
        s0 = n_sclr;
        send_frame(base);
        idle(6);
        n_cmp++;
        if (q_beat.size() - b0 != int'(NPIX + FP)) begin
            n_err++;
            $display("FAIL clean_count got %0d want %0d", q_beat.size() - b0, NPIX + FP);
        end
        for (int k = 0; k < int'(NPIX + FP) && b0 + k < q_beat.size(); k++) begin
            if (k < int'(NPIX)) exp = {1'b0, (k == 0), base + PW'(k)};
            else exp = {1'b1, 1'b0, base + PW'(NPIX - 1)};
            n_cmp++;
            if (q_beat[b0 + k] !== exp) begin
                n_err++;
                $display("FAIL clean_beat[%0d] got %h want %h", k, q_beat[b0 + k], exp);
            end
        end
        n_cmp++;
        if (n_done - d0 != 1) begin
            n_err++;
            $display("FAIL clean_frame_done got %0d cycles want 1", n_done - d0);
        end
        n_cmp++;
        if (n_sclr - s0 != 0 || err_flags !== 3'b000) begin
            n_err++;
            $display("FAIL clean_no_error got sclr=%0d err=%b want 0/000", n_sclr - s0, err_flags);
        end
    endtask

    task automatic test_junk_before_sof;
        int b0;
        logic [PW-1:0] base;
        logic [PW+1:0] exp;
        base = 24'h200000;
        b0 = q_beat.size();
        for (int j = 0; j < 3; j++) send_beat(24'hBAD000 + PW'(j), 1'b0, (j == 2));
        idle(1);
        n_cmp++;
        if (q_beat.size() != b0) begin
            n_err++;
            $display("FAIL junk_dropped got %0d beats want 0", q_beat.size() - b0);
        end
        send_frame(base);
        idle(6);
        n_cmp++;
        if (q_beat.size() - b0 != int'(NPIX + FP)) begin
            n_err++;
            $display("FAIL junk_count got %0d want %0d", q_beat.size() - b0, NPIX + FP);
        end
        for (int k = 0; k < int'(NPIX + FP) && b0 + k < q_beat.size(); k++) begin
            if (k < int'(NPIX)) exp = {1'b0, (k == 0), base + PW'(k)};
            else exp = {1'b1, 1'b0, base + PW'(NPIX - 1)};
            n_cmp++;
            if (q_beat[b0 + k] !== exp) begin
                n_err++;
                $display("FAIL junk_beat[%0d] got %h want %h", k, q_beat[b0 + k], exp);
            end
        end
        n_cmp++;
        if (err_flags !== 3'b000) begin
            n_err++;
            $display("FAIL junk_err_flags got %b want 000", err_flags);
        end
    endtask

    // Sends n_good beats of a broken frame then one faulty beat, then a clean frame.
    task automatic test_geom_error(input string name, input int n_good, input logic bad_last,
                                   input logic [2:0] exp_err);
        int b0;
        int d0;
        int s0;
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [PW+1:0] exp;
        a = 24'h300000;
        b = 24'h400000;
        b0 = q_beat.size();
        d0 = n_done;
        s0 = n_sclr;
        for (int k = 0; k < n_good; k++) send_beat(a + PW'(k), (k == 0), ((k % W) == W - 1));
        if (exp_err[2]) send_frame(b);
        else begin
            send_beat(a + PW'(n_good), 1'b0, bad_last);
            send_frame(b);
        end
        idle(6);
        n_cmp++;
        if (err_flags !== exp_err) begin
            n_err++;
            $display("FAIL %s_err_flags got %b want %b", name, err_flags, exp_err);
        end
        n_cmp++;
        if (n_sclr - s0 != 1) begin
            n_err++;
            $display("FAIL %s_sclr got %0d pulses want 1", name, n_sclr - s0);
        end
        n_cmp++;
        if (n_done - d0 != 1) begin
            n_err++;
            $display("FAIL %s_frame_done got %0d want 1", name, n_done - d0);
        end
        n_cmp++;
        if (q_beat.size() - b0 != n_good + int'(NPIX + FP)) begin
            n_err++;
            $display("FAIL %s_count got %0d want %0d", name, q_beat.size() - b0, n_good + NPIX + FP);
        end
        for (int k = 0; k < n_good + int'(NPIX + FP) && b0 + k < q_beat.size(); k++) begin
            if (k < n_good) exp = {1'b0, (k == 0), a + PW'(k)};
            else if (k < n_good + int'(NPIX)) exp = {1'b0, (k == n_good), b + PW'(k - n_good)};
            else exp = {1'b1, 1'b0, b + PW'(NPIX - 1)};
            n_cmp++;
            if (q_beat[b0 + k] !== exp) begin
                n_err++;
                $display("FAIL %s_beat[%0d] got %h want %h", name, k, q_beat[b0 + k], exp);
            end
        end
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        n_cmp++;
        if (err_flags !== 3'b000) begin
            n_err++;
            $display("FAIL %s_err_clear got %b want 000", name, err_flags);
        end
    endtask

    task automatic test_err_clear_priority;
        int s0;
        s0 = n_sclr;
        err_clear = 1'b1;
        send_beat(24'h500000, 1'b1, 1'b0);
        send_beat(24'h500001, 1'b0, 1'b1);
        idle(3);
        n_cmp++;
        if (n_sclr - s0 != 1 || err_at_sclr !== 3'b000) begin
            n_err++;
            $display("FAIL clear_priority got sclr=%0d err=%b want 1/000", n_sclr - s0, err_at_sclr);
        end
        err_clear = 1'b0;
        idle(1);
        n_cmp++;
        if (err_flags !== 3'b000) begin
            n_err++;
            $display("FAIL clear_priority_after got %b want 000", err_flags);
        end
    endtask

    task automatic test_ready_toggle;
        int b0;
        int d0;
        int v0;
        logic [PW-1:0] base;
        logic [PW+1:0] exp;
        base = 24'h600000;
        b0 = q_beat.size();
        d0 = n_done;
        v0 = n_bad_valid;
        tog_en = 1'b1;
        send_frame(base);
        for (int i = 0; i < 200 && n_done == d0; i++) @(posedge clk);
        #1;
        tog_en = 1'b0;
        idle(3);
        n_cmp++;
        if (n_done - d0 != 1) begin
            n_err++;
            $display("FAIL toggle_frame_done got %0d want 1", n_done - d0);
        end
        n_cmp++;
        if (n_bad_valid != v0) begin
            n_err++;
            $display("FAIL toggle_valid_without_ready got %0d want 0", n_bad_valid - v0);
        end
        n_cmp++;
        if (q_beat.size() - b0 != int'(NPIX + FP)) begin
            n_err++;
            $display("FAIL toggle_count got %0d want %0d", q_beat.size() - b0, NPIX + FP);
        end
        for (int k = 0; k < int'(NPIX + FP) && b0 + k < q_beat.size(); k++) begin
            if (k < int'(NPIX)) exp = {1'b0, (k == 0), base + PW'(k)};
            else exp = {1'b1, 1'b0, base + PW'(NPIX - 1)};
            n_cmp++;
            if (q_beat[b0 + k] !== exp) begin
                n_err++;
                $display("FAIL toggle_beat[%0d] got %h want %h", k, q_beat[b0 + k], exp);
            end
        end
    endtask

    task automatic test_clken_freeze;
        int b0;
        b0 = q_beat.size();
        clken = 1'b0;
        s_axis_tdata  = 24'h700000;
        s_axis_tuser  = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (s_axis_tready !== 1'b0 || pixel_in_valid !== 1'b0) begin
                n_err++;
                $display("FAIL clken_low[%0d] got tready=%b valid=%b want 0/0",
                         i, s_axis_tready, pixel_in_valid);
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        clken = 1'b1;
        idle(2);
        n_cmp++;
        if (q_beat.size() != b0) begin
            n_err++;
            $display("FAIL clken_no_beats got %0d want 0", q_beat.size() - b0);
        end
    endtask

    task automatic test_reset_in_flush;
        int b0;
        int d0;
        int s0;
        int b1;
        logic [PW-1:0] base;
        logic [PW+1:0] exp;
        base = 24'h800000;
        b0 = q_beat.size();
        d0 = n_done;
        s0 = n_sclr;
        send_frame(24'hA00000);
        aresetn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({pixel_in_valid, pixel_pad, sclr, frame_done} !== 4'b0 || err_flags !== 3'b000) begin
            n_err++;
            $display("FAIL flush_reset_outputs got %b err=%b want 0000/000",
                     {pixel_in_valid, pixel_pad, sclr, frame_done}, err_flags);
        end
        n_cmp++;
        if (q_beat.size() - b0 != int'(NPIX)) begin
            n_err++;
            $display("FAIL flush_reset_pre_count got %0d want %0d", q_beat.size() - b0, NPIX);
        end
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        idle(3);
        n_cmp++;
        if (n_sclr != s0 || n_done != d0) begin
            n_err++;
            $display("FAIL flush_reset_no_pulse got sclr=%0d done=%0d want 0/0",
                     n_sclr - s0, n_done - d0);
        end
        b1 = q_beat.size();
        send_frame(base);
        idle(6);
        n_cmp++;
        if (q_beat.size() - b1 != int'(NPIX + FP)) begin
            n_err++;
            $display("FAIL flush_reset_next_count got %0d want %0d", q_beat.size() - b1, NPIX + FP);
        end
        for (int k = 0; k < int'(NPIX + FP) && b1 + k < q_beat.size(); k++) begin
            if (k < int'(NPIX)) exp = {1'b0, (k == 0), base + PW'(k)};
            else exp = {1'b1, 1'b0, base + PW'(NPIX - 1)};
            n_cmp++;
            if (q_beat[b1 + k] !== exp) begin
                n_err++;
                $display("FAIL flush_reset_beat[%0d] got %h want %h", k, q_beat[b1 + k], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_junk_before_sof();
        test_geom_error("early_eol", 2, 1'b1, 3'b001);
        test_geom_error("late_eol", 3, 1'b0, 3'b010);
        test_geom_error("mid_sof", 6, 1'b0, 3'b100);
        test_err_clear_priority();
        test_ready_toggle();
        test_clken_freeze();
        test_reset_in_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
